// File: rtl/ctrl_seq_pkg.sv
// ctrl_seq shared definitions
// opcodes, controller states, decoded-strobe bundle
package ctrl_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_MOV  = 4'h1,
        OP_XOR  = 4'h2,
        OP_AND  = 4'h3,
        OP_LOAD = 4'h4,
        OP_LSH  = 4'h5,
        OP_CMP  = 4'h6,
        OP_STR  = 4'h7,
        OP_B    = 4'h8,
        OP_BEQ  = 4'h9,
        OP_BLT  = 4'hA,
        OP_BGT  = 4'hB,
        OP_HALT = 4'hF
    } op_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        MEMWAIT,
        DONE
    } ctrl_state_t;

    typedef struct packed {
        logic alu;
        logic cmp;
        logic load;
        logic str;
        logic jmp;
        logic beq;
        logic blt;
        logic bgt;
        logic halt;
        logic ill;
    } dec_t;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_seq opcode decoder
// pure combinational opcode -> instruction class
module ctrl_decode
    import ctrl_seq_pkg::*;
#(
    parameter int OPW = 4
) (
    input  logic [OPW-1:0] op,
    output dec_t           dec
);

    // one class bit per opcode group; reserved codes flag as illegal
    always_comb begin
        dec = '0;
        unique case (op)
            OP_ADD, OP_MOV, OP_XOR,
            OP_AND, OP_LSH: dec.alu  = 1'b1;
            OP_CMP:         dec.cmp  = 1'b1;
            OP_LOAD:        dec.load = 1'b1;
            OP_STR:         dec.str  = 1'b1;
            OP_B:           dec.jmp  = 1'b1;
            OP_BEQ:         dec.beq  = 1'b1;
            OP_BLT:         dec.blt  = 1'b1;
            OP_BGT:         dec.bgt  = 1'b1;
            OP_HALT:        dec.halt = 1'b1;
            default:        dec.ill  = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_seq.sv
// ctrl_seq: multi-cycle sequencing controller
// registered CMP flags, memory handshake wait, retire counter
module ctrl_seq
    import ctrl_seq_pkg::*;
#(
    parameter int IW     = 9,
    parameter int OPW    = 4,
    parameter int CNTW   = 16,
    parameter int MEM_TO = 15
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic [IW-1:0]   Instruction,
    input  logic            AluZero,
    input  logic            AluLess,
    input  logic            MemReady,
    output logic            Jump,
    output logic            BranchTaken,
    output logic            RegWrEn,
    output logic            MemWrEn,
    output logic            MemRdEn,
    output logic            LoadInst,
    output logic            PcAdvance,
    output logic            Zero,
    output logic            Ack,
    output logic            MemErr,
    output logic            IllegalOp,
    output logic [CNTW-1:0] RetireCnt
);

    localparam logic [1:0] S_IDLE    = IDLE;
    localparam logic [1:0] S_EXEC    = EXEC;
    localparam logic [1:0] S_MEMWAIT = MEMWAIT;
    localparam logic [1:0] S_DONE    = DONE;

    localparam int WCW = $clog2(MEM_TO + 2);
    localparam bit TO_EN = (MEM_TO > 0);
    localparam logic [WCW-1:0] WLAST =
        WCW'(MEM_TO > 0 ? MEM_TO - 1 : 0);

    logic [1:0]     state;
    logic           zf;
    logic           lf;
    logic           gf;
    logic [WCW-1:0] wcnt;
    logic [OPW-1:0] op;
    logic           mem_op;
    logic           idle_start;
    logic           unused_hi;
    dec_t           dec;

    assign op         = Instruction[OPW-1:0];
    assign unused_hi  = ^Instruction[IW-1:OPW];
    assign mem_op     = dec.load | dec.str;
    assign idle_start = Start &
                        ((state == S_IDLE) | (state == S_DONE));
    assign Zero       = zf;

    ctrl_decode #(
        .OPW (OPW)
    ) u_dec (
        .op  (op),
        .dec (dec)
    );

    // strobes: only live while executing or waiting on memory
    always_comb begin
        Jump        = 1'b0;
        BranchTaken = 1'b0;
        RegWrEn     = 1'b0;
        MemWrEn     = 1'b0;
        MemRdEn     = 1'b0;
        LoadInst    = 1'b0;
        PcAdvance   = 1'b0;
        IllegalOp   = 1'b0;
        if (state == S_EXEC) begin
            Jump        = dec.jmp;
            BranchTaken = (dec.beq & zf) |
                          (dec.blt & lf) |
                          (dec.bgt & gf);
            IllegalOp   = dec.ill;
            MemRdEn     = dec.load;
            MemWrEn     = dec.str;
            LoadInst    = dec.load;
            RegWrEn     = dec.alu | (dec.load & MemReady);
            PcAdvance   = ~dec.halt & (~mem_op | MemReady);
        end else if (state == S_MEMWAIT) begin
            MemRdEn     = dec.load;
            MemWrEn     = dec.str;
            LoadInst    = dec.load;
            RegWrEn     = dec.load & MemReady;
            PcAdvance   = MemReady;
        end
    end

    // sequencing FSM with memory wait timeout and sticky status
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state  <= S_IDLE;
            wcnt   <= '0;
            Ack    <= 1'b0;
            MemErr <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (Start) begin
                        state  <= S_EXEC;
                        Ack    <= 1'b0;
                        MemErr <= 1'b0;
                    end
                end
                S_EXEC: begin
                    if (dec.halt) begin
                        state <= S_DONE;
                        Ack   <= 1'b1;
                    end else if (mem_op && !MemReady) begin
                        state <= S_MEMWAIT;
                        wcnt  <= '0;
                    end
                end
                S_MEMWAIT: begin
                    if (MemReady) begin
                        state <= S_EXEC;
                    end else if (TO_EN && wcnt == WLAST) begin
                        state  <= S_DONE;
                        Ack    <= 1'b1;
                        MemErr <= 1'b1;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // compare flags change only when CMP executes
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            zf <= 1'b0;
            lf <= 1'b0;
            gf <= 1'b0;
        end else if (state == S_EXEC && dec.cmp) begin
            zf <= AluZero;
            lf <= AluLess;
            gf <= ~AluZero & ~AluLess;
        end
    end

    // retired-instruction counter, saturating, cleared on Start
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            RetireCnt <= '0;
        end else if (idle_start) begin
            RetireCnt <= '0;
        end else if (PcAdvance && RetireCnt != '1) begin
            RetireCnt <= RetireCnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_ctrl_seq.sv
// ctrl_seq self-checking bench
// directed scenarios then random opcodes against a behavioural model
module tb_ctrl_seq;

    localparam int IW     = 9;
    localparam int MEM_TO = 15;

    localparam int MD_IDLE = 0;
    localparam int MD_EXEC = 1;
    localparam int MD_WAIT = 2;
    localparam int MD_DONE = 3;

    localparam int B_JMP = 10;
    localparam int B_BT  = 9;
    localparam int B_RW  = 8;
    localparam int B_MW  = 7;
    localparam int B_MR  = 6;
    localparam int B_LI  = 5;
    localparam int B_PC  = 4;
    localparam int B_Z   = 3;
    localparam int B_ACK = 2;
    localparam int B_ERR = 1;
    localparam int B_ILL = 0;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          Start = 1'b0;
    logic [IW-1:0] Instruction = '0;
    logic          AluZero = 1'b0;
    logic          AluLess = 1'b0;
    logic          MemReady = 1'b0;

    logic Jump, BranchTaken, RegWrEn, MemWrEn, MemRdEn;
    logic LoadInst, PcAdvance, Zero, Ack, MemErr, IllegalOp;
    logic [15:0] RetireCnt;

    logic b_Jump, b_BranchTaken, b_RegWrEn, b_MemWrEn, b_MemRdEn;
    logic b_LoadInst, b_PcAdvance, b_Zero, b_Ack, b_MemErr;
    logic b_IllegalOp;
    logic [1:0] b_RetireCnt;

    ctrl_seq #(
        .IW(IW), .OPW(4), .CNTW(16), .MEM_TO(MEM_TO)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start),
        .Instruction(Instruction), .AluZero(AluZero),
        .AluLess(AluLess), .MemReady(MemReady),
        .Jump(Jump), .BranchTaken(BranchTaken),
        .RegWrEn(RegWrEn), .MemWrEn(MemWrEn),
        .MemRdEn(MemRdEn), .LoadInst(LoadInst),
        .PcAdvance(PcAdvance), .Zero(Zero), .Ack(Ack),
        .MemErr(MemErr), .IllegalOp(IllegalOp),
        .RetireCnt(RetireCnt)
    );

    ctrl_seq #(
        .IW(IW), .OPW(4), .CNTW(2), .MEM_TO(MEM_TO)
    ) dut_small (
        .Clk(Clk), .Reset(Reset), .Start(Start),
        .Instruction(Instruction), .AluZero(AluZero),
        .AluLess(AluLess), .MemReady(MemReady),
        .Jump(b_Jump), .BranchTaken(b_BranchTaken),
        .RegWrEn(b_RegWrEn), .MemWrEn(b_MemWrEn),
        .MemRdEn(b_MemRdEn), .LoadInst(b_LoadInst),
        .PcAdvance(b_PcAdvance), .Zero(b_Zero), .Ack(b_Ack),
        .MemErr(b_MemErr), .IllegalOp(b_IllegalOp),
        .RetireCnt(b_RetireCnt)
    );

    always #5 Clk = ~Clk;

    int n_chk = 0;
    int n_fail = 0;

    int m_mode;
    int m_cnt;
    int m_cnt2;
    int m_wait;
    bit zf, lf, gf, m_ack, m_err;

    logic [10:0] s_vec;

    function automatic logic [10:0] outs_a();
        return {Jump, BranchTaken, RegWrEn, MemWrEn, MemRdEn,
                LoadInst, PcAdvance, Zero, Ack, MemErr, IllegalOp};
    endfunction

    function automatic logic [10:0] outs_b();
        return {b_Jump, b_BranchTaken, b_RegWrEn, b_MemWrEn,
                b_MemRdEn, b_LoadInst, b_PcAdvance, b_Zero,
                b_Ack, b_MemErr, b_IllegalOp};
    endfunction

    function automatic logic [IW-1:0] mk(input logic [3:0] op);
        return {5'($urandom), op};
    endfunction

    // expected outputs from the opcode rules and the model state
    function automatic logic [10:0] exp_vec();
        int op;
        bit alu, ld, sr, hl, il, j, bt, rw, mw, mrd, li, pc;
        op  = int'(Instruction[3:0]);
        alu = (op <= 3) || (op == 5);
        ld  = (op == 4);
        sr  = (op == 7);
        hl  = (op == 15);
        j = 0; bt = 0; rw = 0; mw = 0;
        mrd = 0; li = 0; pc = 0; il = 0;
        if (m_mode == MD_EXEC) begin
            j   = (op == 8);
            bt  = (op == 9 && zf) || (op == 10 && lf) ||
                  (op == 11 && gf);
            il  = (op >= 12 && op <= 14);
            mrd = ld;
            mw  = sr;
            li  = ld;
            rw  = alu || (ld && MemReady);
            pc  = !hl && (!(ld || sr) || MemReady);
        end else if (m_mode == MD_WAIT) begin
            mrd = ld;
            mw  = sr;
            li  = ld;
            rw  = ld && MemReady;
            pc  = MemReady;
        end
        return {j, bt, rw, mw, mrd, li, pc, zf, m_ack, m_err, il};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = MD_IDLE;
        m_cnt  = 0;
        m_cnt2 = 0;
        m_wait = 0;
        zf = 0; lf = 0; gf = 0;
        m_ack = 0; m_err = 0;
    endtask

    task automatic model_step(input bit st, input bit az,
                              input bit al, input bit mr,
                              input logic [3:0] op);
        bit ld, sr, retire;
        ld = (op == 4);
        sr = (op == 7);
        retire = 0;
        case (m_mode)
            MD_IDLE, MD_DONE: begin
                if (st) begin
                    m_mode = MD_EXEC;
                    m_cnt = 0; m_cnt2 = 0;
                    m_ack = 0; m_err = 0;
                end
            end
            MD_EXEC: begin
                if (op == 6) begin
                    zf = az; lf = al; gf = !az && !al;
                end
                if (op == 15) begin
                    m_mode = MD_DONE;
                    m_ack = 1;
                end else if ((ld || sr) && !mr) begin
                    m_mode = MD_WAIT;
                    m_wait = 0;
                end else begin
                    retire = 1;
                end
            end
            default: begin
                if (mr) begin
                    retire = 1;
                    m_mode = MD_EXEC;
                end else begin
                    m_wait++;
                    if (MEM_TO > 0 && m_wait == MEM_TO) begin
                        m_err = 1;
                        m_ack = 1;
                        m_mode = MD_DONE;
                    end
                end
            end
        endcase
        if (retire) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
    endtask

    // one clock: drive, check mid-cycle, advance model after edge
    task automatic cyc(input logic [IW-1:0] ins, input bit st,
                       input bit az, input bit al, input bit mr,
                       input string tag);
        Instruction = ins;
        Start = st;
        AluZero = az;
        AluLess = al;
        MemReady = mr;
        @(negedge Clk);
        s_vec = outs_a();
        chk({tag, " outs"}, 32'(s_vec), 32'(exp_vec()));
        chk({tag, " outs_small"}, 32'(outs_b()), 32'(exp_vec()));
        chk({tag, " cnt"}, 32'(RetireCnt), 32'(m_cnt));
        chk({tag, " cnt_small"}, 32'(b_RetireCnt), 32'(m_cnt2));
        @(posedge Clk);
        #1;
        model_step(st, az, al, mr, ins[3:0]);
    endtask

    initial begin
        int rd_n, rw_n, pc_n, mw_n;
        logic [IW-1:0] cur;
        bit st;
        model_reset();
        cur = '0;

        #1 Reset = 1'b0;
        #2;
        chk("reset outs", 32'(outs_a()), 32'd0);
        chk("reset cnt", 32'(RetireCnt), 32'd0);
        #9 Reset = 1'b1;
        @(posedge Clk);
        #1;

        cyc(mk(4'h0), 0, 0, 0, 0, "idle");
        cyc(mk(4'h0), 1, 0, 0, 0, "start1");
        cyc(mk(4'h0), 0, 0, 0, 0, "add");
        chk("add regwr", 32'(s_vec[B_RW]), 32'd1);
        cyc(mk(4'h1), 0, 0, 0, 0, "mov");
        chk("mov pcadv", 32'(s_vec[B_PC]), 32'd1);
        cyc(mk(4'hF), 0, 0, 0, 0, "halt");
        chk("halt pcadv", 32'(s_vec[B_PC]), 32'd0);
        cyc(mk(4'h0), 0, 0, 0, 0, "done");
        chk("done ack", 32'(s_vec[B_ACK]), 32'd1);
        chk("done cnt", 32'(RetireCnt), 32'd2);

        cyc(mk(4'h6), 1, 0, 0, 0, "start2");
        cyc(mk(4'h6), 0, 1, 0, 0, "cmp_eq");
        cyc(mk(4'h9), 0, 0, 0, 0, "beq");
        chk("beq taken", 32'(s_vec[B_BT]), 32'd1);
        chk("beq zero", 32'(s_vec[B_Z]), 32'd1);
        cyc(mk(4'h6), 0, 0, 1, 0, "cmp_lt");
        cyc(mk(4'hB), 0, 1, 1, 0, "bgt");
        chk("bgt taken", 32'(s_vec[B_BT]), 32'd0);
        cyc(mk(4'hA), 0, 0, 0, 0, "blt");
        chk("blt taken", 32'(s_vec[B_BT]), 32'd1);
        cyc(mk(4'h8), 0, 0, 0, 0, "b");
        chk("b jump", 32'(s_vec[B_JMP]), 32'd1);

        rd_n = 0; rw_n = 0; pc_n = 0;
        cur = mk(4'h4);
        for (int i = 0; i < 4; i++) begin
            cyc(cur, 0, 0, 0, i == 3, "load");
            rd_n += int'(s_vec[B_MR]);
            rw_n += int'(s_vec[B_RW]);
            pc_n += int'(s_vec[B_PC]);
        end
        chk("load rd cycles", 32'(rd_n), 32'd4);
        chk("load rw cycles", 32'(rw_n), 32'd1);
        chk("load pc cycles", 32'(pc_n), 32'd1);
        chk("load last li", 32'(s_vec[B_LI]), 32'd1);

        mw_n = 0; rw_n = 0;
        cur = mk(4'h7);
        for (int i = 0; i < 16; i++) begin
            cyc(cur, 0, 0, 0, 0, "str_to");
            mw_n += int'(s_vec[B_MW]);
            rw_n += int'(s_vec[B_RW]);
        end
        chk("str ack before", 32'(s_vec[B_ACK]), 32'd0);
        chk("str wr cycles", 32'(mw_n), 32'd16);
        chk("str no regwr", 32'(rw_n), 32'd0);
        cyc(mk(4'h0), 0, 0, 0, 0, "after_to");
        chk("timeout err", 32'(s_vec[B_ERR]), 32'd1);
        chk("timeout ack", 32'(s_vec[B_ACK]), 32'd1);

        cyc(mk(4'h0), 1, 0, 0, 0, "start3");
        chk("start3 err held", 32'(s_vec[B_ERR]), 32'd1);
        cyc(mk(4'hD), 0, 0, 0, 0, "illegal");
        chk("illegal pulse", 32'(s_vec[B_ILL]), 32'd1);
        chk("illegal pcadv", 32'(s_vec[B_PC]), 32'd1);
        cyc(mk(4'h0), 0, 0, 0, 0, "after_ill");
        chk("illegal one cycle", 32'(s_vec[B_ILL]), 32'd0);
        cyc(mk(4'hC), 0, 0, 0, 0, "nop");
        cyc(mk(4'hD), 0, 0, 0, 0, "nop");
        cyc(mk(4'hE), 0, 0, 0, 0, "nop");
        cyc(mk(4'hC), 0, 0, 0, 0, "nop");
        cyc(mk(4'hE), 0, 0, 0, 0, "nop");
        chk("sat cnt small", 32'(b_RetireCnt), 32'd3);
        chk("cnt wide", 32'(RetireCnt), 32'd7);

        cur = mk(4'h7);
        cyc(cur, 0, 0, 0, 0, "str_pre_rst");
        cyc(cur, 0, 0, 0, 0, "wait_pre_rst");
        chk("pre rst memwr", 32'(MemWrEn), 32'd1);
        #2 Reset = 1'b0;
        #1;
        chk("mid rst outs", 32'(outs_a()), 32'd0);
        chk("mid rst cnt", 32'(RetireCnt), 32'd0);
        model_reset();
        #1 Reset = 1'b1;
        @(posedge Clk);
        #1;
        cyc(cur, 0, 0, 0, 1, "post_rst");

        for (int i = 0; i < 400; i++) begin
            if (m_mode != MD_WAIT) begin
                if ($urandom_range(0, 19) == 0)
                    cur = mk(4'hF);
                else
                    cur = mk(4'($urandom_range(0, 14)));
            end
            if (m_mode == MD_IDLE || m_mode == MD_DONE)
                st = 1'b1;
            else
                st = ($urandom_range(0, 7) == 0);
            cyc(cur, st, 1'($urandom), 1'($urandom),
                $urandom_range(0, 2) == 0, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
